// File: rtl/alien_bomb.sv
// Enemy bomb pool: requests shooters from the alien grid on an LFSR-jittered
// cooldown, drops bombs each frame, reports ship hits and draws the bomb layer.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_COOL | counting down frames; waits for cooldown 0 and a free slot
// S_REQ  | shot_req high, waiting for shot_valid or shot_empty
module alien_bomb #(
  parameter int          NUM_BOMBS     = 4,
  parameter int          BOMB_SPEED    = 3,
  parameter int          BOMB_W        = 4,
  parameter int          BOMB_H        = 10,
  parameter int          COOLDOWN_MIN  = 30,
  parameter logic [5:0]  COOLDOWN_MASK = 6'h3F,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [23:0] BOMB_COLOR    = 24'hFF4000,
  parameter int          VRES          = 480,
  parameter int          PADDLE_W      = 32,
  parameter int          PADDLE_H      = 8
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  fsync,
  input  logic                  game_active,
  input  logic [11:0]           player_x,
  input  logic signed [11:0]    hpos,
  input  logic signed [11:0]    vpos,
  output logic                  shot_req,
  output logic [2:0]            shot_col,
  input  logic                  shot_valid,
  input  logic                  shot_empty,
  input  logic signed [11:0]    shot_x,
  input  logic signed [11:0]    shot_y,
  output logic [2:0][7:0]       pixel,
  output logic                  player_hit,
  output logic [NUM_BOMBS-1:0]  bombs_active
);

  localparam int IDX_W = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1;
  localparam logic [7:0] CD_MIN = 8'(COOLDOWN_MIN);

  // Geometry is compared in 14-bit signed so box edges never wrap.
  localparam logic signed [13:0] HALF_W  = 14'(BOMB_W / 2);
  localparam logic signed [13:0] BOX_H   = 14'(BOMB_H);
  localparam logic signed [13:0] SPEED   = 14'(BOMB_SPEED);
  localparam logic signed [13:0] VRES_S  = 14'(VRES);
  localparam logic signed [13:0] SHIP_HW = 14'(PADDLE_W / 2);
  localparam logic signed [13:0] SHIP_T  = 14'(VRES - PADDLE_H);
  localparam logic signed [13:0] SHIP_B  = 14'(VRES - 1);

  typedef enum logic {S_COOL, S_REQ} state_t;

  state_t               state, state_nx;
  logic [7:0]           cooldown, cd_dec;
  logic [15:0]          lfsr, lfsr_nx;
  logic signed [11:0]   bx [NUM_BOMBS];
  logic signed [11:0]   by [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] hit_vec, bottom_vec, draw_vec;
  logic [IDX_W-1:0]     free_idx;
  logic                 free_any, take_shot;
  logic signed [13:0]   ship_l, ship_r;

  function automatic logic signed [13:0] sx(input logic signed [11:0] v);
    return {{2{v[11]}}, v};
  endfunction

  assign lfsr_nx   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign cd_dec    = (fsync && cooldown != 8'd0) ? cooldown - 8'd1 : cooldown;
  assign free_any  = ~&bombs_active;
  assign take_shot = (state == S_REQ) && game_active && shot_valid;
  assign ship_l    = $signed({2'b00, player_x}) - SHIP_HW;
  assign ship_r    = $signed({2'b00, player_x}) + SHIP_HW;

  always_comb begin
    free_idx = '0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (!bombs_active[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    hit_vec    = '0;
    bottom_vec = '0;
    draw_vec   = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      hit_vec[i] = bombs_active[i]
                   && (sx(bx[i]) - HALF_W <= ship_r) && (sx(bx[i]) + HALF_W >= ship_l)
                   && (sx(by[i]) <= SHIP_B) && (sx(by[i]) + BOX_H >= SHIP_T);
      bottom_vec[i] = (sx(by[i]) + SPEED >= VRES_S);
      draw_vec[i] = bombs_active[i]
                    && (sx(hpos) >= sx(bx[i]) - HALF_W) && (sx(hpos) <= sx(bx[i]) + HALF_W)
                    && (sx(vpos) >= sx(by[i])) && (sx(vpos) <= sx(by[i]) + BOX_H);
    end
  end

  assign pixel = (|draw_vec) ? BOMB_COLOR : 24'h000000;

  always_ff @(posedge pixel_clk) begin
    if (rst) state <= S_COOL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!game_active) begin
      state_nx = S_COOL;
    end else begin
      case (state)
        S_COOL: if (cd_dec == 8'd0 && free_any) state_nx = S_REQ;
        S_REQ:  if (shot_valid || shot_empty)   state_nx = S_COOL;
      endcase
    end
  end

  always_comb begin
    shot_req = (state == S_REQ);
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      lfsr       <= LFSR_SEED;
      cooldown   <= CD_MIN;
      shot_col   <= '0;
      player_hit <= 1'b0;
    end else begin
      lfsr       <= lfsr_nx;
      player_hit <= game_active && fsync && (|hit_vec);
      if (!game_active) begin
        cooldown <= CD_MIN;
      end else if (state == S_REQ) begin
        if (shot_valid)      cooldown <= CD_MIN + {2'b00, lfsr[5:0] & COOLDOWN_MASK};
        else if (shot_empty) cooldown <= 8'd1;
      end else begin
        cooldown <= cd_dec;
        if (state_nx == S_REQ) shot_col <= lfsr[2:0];
      end
    end
  end

  // A freshly loaded slot is inactive before this edge, so the move loop never touches it.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      bombs_active <= '0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
        bx[i] <= '0;
        by[i] <= '0;
      end
    end else if (!game_active) begin
      bombs_active <= '0;
    end else begin
      if (fsync) begin
        for (int i = 0; i < NUM_BOMBS; i++) begin
          if (bombs_active[i]) begin
            if (hit_vec[i] || bottom_vec[i]) bombs_active[i] <= 1'b0;
            else                             by[i] <= by[i] + 12'(BOMB_SPEED);
          end
        end
      end
      if (take_shot) begin
        bombs_active[free_idx] <= 1'b1;
        bx[free_idx]           <= shot_x;
        by[free_idx]           <= shot_y;
      end
    end
  end

endmodule

// File: tb/tb_alien_bomb.sv
// Bench for alien_bomb: directed scenarios plus random traffic, all checked
// against a frame-level behavioural model of the bomb pool.
module tb_alien_bomb;

  localparam int NB    = 4;
  localparam int SPD   = 3;
  localparam int BW    = 4;
  localparam int BH    = 10;
  localparam int CMIN  = 30;
  localparam int CMASK = 'h3F;
  localparam int SEED  = 'hACE1;
  localparam int COLOR = 'hFF4000;
  localparam int VRES  = 480;
  localparam int PW    = 32;
  localparam int PH    = 8;

  logic              clk = 1'b0;
  logic              rst, fsync, game_active, shot_valid, shot_empty;
  logic [11:0]       player_x, hpos, vpos, shot_x, shot_y;
  logic              shot_req, player_hit;
  logic [2:0]        shot_col;
  logic [2:0][7:0]   pixel;
  logic [NB-1:0]     bombs_active;

  int n_checks = 0;
  int n_errors = 0;

  alien_bomb dut (
    .pixel_clk    (clk),
    .rst          (rst),
    .fsync        (fsync),
    .game_active  (game_active),
    .player_x     (player_x),
    .hpos         (hpos),
    .vpos         (vpos),
    .shot_req     (shot_req),
    .shot_col     (shot_col),
    .shot_valid   (shot_valid),
    .shot_empty   (shot_empty),
    .shot_x       (shot_x),
    .shot_y       (shot_y),
    .pixel        (pixel),
    .player_hit   (player_hit),
    .bombs_active (bombs_active)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference model: a list of bombs with integer coordinates.
  int m_on [NB];
  int m_x  [NB];
  int m_y  [NB];
  int m_cd, m_col, m_lfsr;
  bit m_req, m_hit;

  function automatic int sx12(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  function automatic int lfsr_next(input int l);
    int n;
    n = l >> 1;
    if ((l & 1) != 0) n = n ^ 'hB400;
    return n;
  endfunction

  function automatic bit overlaps_ship(input int x, input int y, input int px);
    return (x - BW/2 <= px + PW/2) && (x + BW/2 >= px - PW/2)
        && (y <= VRES - 1) && (y + BH >= VRES - PH);
  endfunction

  function automatic int model_pix(input int h, input int v);
    for (int i = 0; i < NB; i++)
      if (m_on[i] != 0 && h >= m_x[i] - BW/2 && h <= m_x[i] + BW/2 && v >= m_y[i] && v <= m_y[i] + BH)
        return COLOR;
    return 0;
  endfunction

  function automatic int model_mask();
    int m;
    m = 0;
    for (int i = 0; i < NB; i++) if (m_on[i] != 0) m |= (1 << i);
    return m;
  endfunction

  task automatic model_step(input bit r, input bit ga, input bit f, input bit sv, input bit se,
                            input int px, input int sxv, input int syv);
    int was_on [NB];
    int free_idx;
    bit any_hit;
    if (r) begin
      for (int i = 0; i < NB; i++) begin m_on[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_cd = CMIN; m_req = 0; m_col = 0; m_hit = 0; m_lfsr = SEED;
      return;
    end
    if (!ga) begin
      for (int i = 0; i < NB; i++) m_on[i] = 0;
      m_cd = CMIN; m_req = 0; m_hit = 0;
    end else begin
      was_on = m_on;
      free_idx = -1;
      for (int i = NB - 1; i >= 0; i--) if (was_on[i] == 0) free_idx = i;
      any_hit = 0;
      if (f) begin
        for (int i = 0; i < NB; i++) begin
          if (was_on[i] != 0) begin
            if (overlaps_ship(m_x[i], m_y[i], px)) begin m_on[i] = 0; any_hit = 1; end
            else if (m_y[i] + SPD >= VRES) m_on[i] = 0;
            else m_y[i] += SPD;
          end
        end
      end
      m_hit = f && any_hit;
      if (m_req) begin
        if (sv) begin
          if (free_idx >= 0) begin
            m_on[free_idx] = 1; m_x[free_idx] = sxv; m_y[free_idx] = syv;
          end
          m_cd = CMIN + ((m_lfsr & 'h3F) & CMASK);
          m_req = 0;
        end else if (se) begin
          m_cd = 1;
          m_req = 0;
        end
      end else begin
        if (f && m_cd > 0) m_cd--;
        if (m_cd == 0 && free_idx >= 0) begin m_req = 1; m_col = m_lfsr & 7; end
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  int fs_period, fs_cnt, resp_kind, resp_delay, req_age;
  bit last_f;

  task automatic probe(input int h, input int v, input string tag);
    hpos = 12'(h);
    vpos = 12'(v);
    #1;
    check_val(tag, pixel, model_pix(sx12(hpos), sx12(vpos)));
  endtask

  task automatic cycle();
    bit f, sv, se;
    int r, s;
    @(negedge clk);
    if (fs_period > 0) begin fs_cnt++; f = (fs_cnt % fs_period) == 0; end
    else f = ($urandom_range(0, 1) == 0);
    sv = 0; se = 0;
    if (resp_kind == 2) begin
      r = int'($urandom_range(0, 15));
      if (m_req) begin sv = (r < 3) || (r == 5); se = (r >= 3) && (r < 6); end
      else begin sv = (r == 15); se = (r == 14); end
    end else if (m_req && req_age >= resp_delay) begin
      sv = (resp_kind == 0);
      se = (resp_kind == 1);
    end
    fsync = f; shot_valid = sv; shot_empty = se;
    model_step(rst, game_active, f, sv, se, int'(player_x), sx12(shot_x), sx12(shot_y));
    req_age = m_req ? req_age + 1 : 0;
    @(posedge clk);
    #1;
    check_val("shot_req", shot_req, m_req);
    check_val("shot_col", shot_col, m_col);
    check_val("bombs_active", bombs_active, model_mask());
    check_val("player_hit", player_hit, m_hit);
    for (int k = 0; k < 2; k++) begin
      s = int'($urandom_range(0, NB - 1));
      if (m_on[s] != 0) probe(m_x[s] + int'($urandom_range(0, 6)) - 3, m_y[s] + int'($urandom_range(0, 12)) - 1, "pix_edge");
      else probe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), "pix_rand");
    end
    last_f = f;
  endtask

  int  nfs, hits, frames, cnt, sav_x[NB], sav_y[NB], sav_on[NB];
  bit  found;
  logic [NB-1:0] mask_before;

  initial begin
    rst = 1; game_active = 0; fsync = 0; shot_valid = 0; shot_empty = 0;
    player_x = 12'd1000; shot_x = 12'd320; shot_y = 12'd100; hpos = '0; vpos = '0;
    fs_period = 4; fs_cnt = 0; resp_kind = 0; resp_delay = 2; req_age = 0; last_f = 0;

    repeat (3) cycle();
    check_val("rst_active", bombs_active, 0);
    check_val("rst_req", shot_req, 0);
    check_val("rst_col", shot_col, 0);
    check_val("rst_hit", player_hit, 0);

    // First shot after 30 frames
    rst = 0; game_active = 1; fs_cnt = 0; nfs = 0; found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      cycle();
      if (last_f) nfs++;
      if (shot_req) found = 1;
    end
    check_val("first_req_seen", found, 1);
    check_val("first_req_fsyncs", nfs, 30);
    check_val("first_req_after_fsync", last_f, 1);

    for (int c = 0; c < 10 && !bombs_active[0]; c++) cycle();
    check_val("slot0_spawn", bombs_active[0], 1);
    frames = 0;
    for (int c = 0; c < 100 && frames < 10; c++) begin
      cycle();
      if (last_f) frames++;
    end
    hpos = 12'd320; vpos = 12'd130; #1; check_val("slot0_top", pixel, COLOR);
    vpos = 12'd129; #1; check_val("slot0_above", pixel, 0);
    vpos = 12'd140; #1; check_val("slot0_bottom", pixel, COLOR);
    hpos = 12'd323; #1; check_val("slot0_right", pixel, 0);

    // Ship under the falling bomb
    player_x = 12'd320; hits = 0;
    for (int c = 0; c < 2000; c++) begin
      cycle();
      if (!bombs_active[0]) break;
      if (player_hit) hits++;
    end
    check_val("slot0_cleared", bombs_active[0], 0);
    check_val("hit_on_clear", player_hit, 1);
    check_val("hits_before_clear", hits, 0);
    cycle();
    check_val("hit_one_cycle", player_hit, 0);

    // Bomb misses the ship and leaves the screen
    game_active = 0; cycle();
    check_val("clear_all", bombs_active, 0);
    game_active = 1; player_x = 12'd500; shot_x = 12'd100; shot_y = 12'd100;
    for (int c = 0; c < 600 && !bombs_active[0]; c++) cycle();
    check_val("miss_spawn", bombs_active[0], 1);
    frames = 0; hits = 0;
    for (int c = 0; c < 1000; c++) begin
      cycle();
      if (last_f) frames++;
      if (player_hit) hits++;
      if (!bombs_active[0]) break;
    end
    check_val("bottom_frames", frames, 127);
    check_val("bottom_no_hit", hits, 0);

    // Fill the pool with slow bombs far above the screen
    game_active = 0; cycle();
    game_active = 1; shot_x = 12'd320; shot_y = 12'(-2000); player_x = 12'd1000; fs_period = 2;
    for (int c = 0; c < 4000 && bombs_active != 4'hF; c++) cycle();
    check_val("pool_full", bombs_active, 4'hF);
    cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      cycle();
      if (bombs_active != 4'hF) break;
      if (shot_req) cnt++;
    end
    check_val("no_req_while_full", cnt, 0);
    check_val("slot_freed", bombs_active != 4'hF, 1);
    resp_kind = 1;
    cycle();
    check_val("req_after_free", shot_req, 1);

    // Empty column answer
    mask_before = bombs_active;
    for (int c = 0; c < 10 && shot_req; c++) cycle();
    check_val("empty_req_drop", shot_req, 0);
    check_val("empty_no_alloc", bombs_active, mask_before);
    nfs = 0;
    for (int c = 0; c < 20 && !shot_req; c++) begin
      cycle();
      if (last_f) nfs++;
    end
    check_val("empty_retry_fsyncs", nfs, 1);
    check_val("empty_retry_edge", last_f, 1);

    // Drop game_active mid-request with three bombs live
    check_val("three_live", $countones(bombs_active), 3);
    for (int i = 0; i < NB; i++) begin sav_on[i] = m_on[i]; sav_x[i] = m_x[i]; sav_y[i] = m_y[i]; end
    game_active = 0;
    cycle();
    check_val("drop_mask", bombs_active, 0);
    check_val("drop_req", shot_req, 0);
    for (int i = 1; i < NB; i++) begin
      hpos = 12'(sav_x[i]); vpos = 12'(sav_y[i] + 5); #1;
      check_val("drop_pixel", pixel, 0);
    end

    // Random traffic
    resp_kind = 2; fs_period = 0;
    for (int c = 0; c < 6000; c++) begin
      rst         = ($urandom_range(0, 599) == 0);
      game_active = ($urandom_range(0, 299) != 0);
      player_x    = 12'(300 + int'($urandom_range(0, 40)));
      shot_x      = 12'(300 + int'($urandom_range(0, 40)));
      shot_y      = 12'(int'($urandom_range(300, 470)));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alien_bomb.md
# alien_bomb

Enemy-projectile engine: the downward counterpart of the player bullet. It holds a small pool of alien bombs and requests a shooter from the alien grid on a pseudo-random cooldown. Each frame it moves the bombs down the screen, tests them against the player ship and reports `player_hit`. It also drives the bomb RGB layer for the pixel mixer.

## Interface
- `NUM_BOMBS`, 4: bomb slots.
- `BOMB_SPEED`, 3: pixels moved per frame.
- `BOMB_W`, 4; `BOMB_H`, 10: bomb box size.
- `COOLDOWN_MIN`, 30: minimum frames between shots.
- `COOLDOWN_MASK`, 6'h3F: random extra frames, `lfsr[5:0] & COOLDOWN_MASK`.
- `LFSR_SEED`, 16'hACE1: LFSR reset value, nonzero.
- `BOMB_COLOR`, 24'hFF4000: RGB.
- Screen and ship geometry (`VRES`, `PADDLE_W`, `PADDLE_H`) come from `params`.
- `pixel_clk` in 1: the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `fsync` in 1: one-cycle frame tick.
- `game_active` in 1: low clears all bombs.
- `player_x` in 12: ship centre X (unsigned).
- `hpos`, `vpos` in 12 signed: current pixel.
- `shot_req` out 1: request for a shooter.
- `shot_col` out 3: random alien column to shoot from.
- `shot_valid` in 1: responder supplies a shooter position.
- `shot_empty` in 1: the requested column has no live alien.
- `shot_x`, `shot_y` in 12 signed: bomb spawn point (centre X, top Y).
- `pixel` out [7:0] x3: [2]=R, [1]=G, [0]=B.
- `player_hit` out 1: one-cycle pulse.
- `bombs_active` out `NUM_BOMBS`: per-slot active mask.

## Operation
- **LFSR:** 16-bit Galois, taps 16,14,13,11. Advances every cycle.
- **Per-slot state:** `active`, `x`, `y`, all 12-bit signed.
- **Bomb box:** left = x − `BOMB_W`/2, right = x + `BOMB_W`/2, top = y, bottom = y + `BOMB_H`. All bounds inclusive.
- **Ship box:** X from `player_x` − `PADDLE_W`/2 to `player_x` + `PADDLE_W`/2; Y from `VRES` − `PADDLE_H` to `VRES` − 1.
- **FSM, two states:**
  - COOL: on each `fsync` with `game_active`, decrement `cooldown` if it is nonzero. When `cooldown` is 0 and a free slot exists, go to REQ and latch `shot_col`=`lfsr[2:0]`. With no free slot, stay in COOL with `cooldown` held at 0 and retry every cycle.
  - REQ: `shot_req`=1.
    - On `shot_valid`: load the lowest-index free slot with (`shot_x`, `shot_y`) and set it active. Reload `cooldown` = `COOLDOWN_MIN` + (`lfsr[5:0]` & `COOLDOWN_MASK`). Go to COOL.
    - On `shot_empty`: set `cooldown`=1 and go to COOL, so the retry happens next frame.
    - If both are asserted, `shot_valid` wins.
- **Frame update on `fsync`, per slot active before this cycle:**
  - If the bomb box overlaps the ship box (evaluated on the pre-move position): clear the slot and count it as a hit.
  - Otherwise, if y + `BOMB_SPEED` ≥ `VRES`: clear the slot.
  - Otherwise: y += `BOMB_SPEED`.
- **Hit reporting:** `player_hit` is asserted exactly once per frame in which at least one slot hit. All hitting slots clear together.
- **`fsync` and `shot_valid` in the same cycle:** the newly loaded slot is not moved that frame; movement applies only to slots already active.
- **`game_active` low, any cycle:** all slots cleared, state COOL, `cooldown`=`COOLDOWN_MIN`, `shot_req`=0. A REQ in flight is abandoned.
- **Drawing (combinational):** `pixel` = `BOMB_COLOR` if `hpos`/`vpos` falls inside any active slot's box, else 0.

## Timing
- **Reset values:** all slots inactive, `bombs_active`=0, `shot_req`=0, `shot_col`=0, `player_hit`=0, state COOL, `cooldown`=`COOLDOWN_MIN`, LFSR=`LFSR_SEED`. `pixel`=0 follows from the empty slots.
- **Request latency:** `shot_req` is registered and rises 1 cycle after the cycle in which `cooldown` reaches 0. It falls on the edge that samples `shot_valid` or `shot_empty`.
- **Responder:** may answer in any cycle while `shot_req`=1, with no upper bound. `shot_x`/`shot_y` are sampled only when `shot_valid`=1.
- **Spawn latency:** the new slot's bit in `bombs_active` rises on the same edge that drops `shot_req`.
- **Hit latency:** `player_hit` pulses for 1 cycle, on the cycle after the `fsync`.
- **Reset mid-operation:** `rst` overrides everything on the next edge.

## Test plan
- Reset, `game_active`=1, responder answers `shot_valid` 2 cycles after each `shot_req` with (320,100). Required:
  - first `shot_req` 1 cycle after the 30th `fsync`;
  - slot0 active;
  - after 10 more frames, slot0 y=130.
- Bomb at x=320, `player_x`=320, frames run until the box reaches y ≥ `VRES` − `PADDLE_H` − `BOMB_H`. Required: the slot clears and `player_hit` is a single 1-cycle pulse; every frame before that produces no pulse.
- Bomb at x=100, `player_x`=500. Required: the bomb clears on the frame where y + 3 ≥ `VRES`, with no hit.
- Fill all 4 slots. Required: no `shot_req` while the pool is full; `shot_req` rises within 1 cycle of a slot freeing.
- `shot_empty` response. Required: no slot allocated, and a new `shot_req` follows the next `fsync`.
- Drop `game_active` while in REQ with 3 bombs live. Required: next cycle `bombs_active`=0, `shot_req`=0, `pixel`=0 everywhere.
